// File: rtl/step_ctrl_pkg.sv
// Shared types and default timing constants for the stepper ramp controller.
package step_ctrl_pkg;

    localparam int unsigned N_W   = 17;
    localparam int unsigned DIV_W = 16;

    localparam logic [N_W-1:0]   N_START_DEF   = 17'd8333;
    localparam logic [N_W-1:0]   N_MIN_DEF     = 17'd1000;
    localparam logic [N_W-1:0]   RAMP_STEP_DEF = 17'd16;
    localparam logic [DIV_W-1:0] RAMP_DIV_DEF  = 16'd5000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAMP     = 2'd1,
        ST_RUN      = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

    // Clamp by comparison only, so no intermediate can wrap.
    function automatic logic [N_W-1:0] clamp_n(input logic [N_W-1:0] v,
                                                input logic [N_W-1:0] lo,
                                                input logic [N_W-1:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

// File: rtl/ramp_tick_div.sv
// Ramp-rate divider: counts 0..RAMP_DIV-1 while not cleared, ticks on the last count.
module ramp_tick_div
    import step_ctrl_pkg::*;
#(
    parameter logic [DIV_W-1:0] RAMP_DIV = RAMP_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = !clear && (cnt == RAMP_DIV - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/step_ramp_ctrl.sv
// Stepper period controller: accelerates/decelerates the pulse period toward a
// manual or tracker target, with a controlled stop back to the start period.
module step_ramp_ctrl
    import step_ctrl_pkg::*;
#(
    parameter logic [N_W-1:0]   N_START   = N_START_DEF,
    parameter logic [N_W-1:0]   N_MIN     = N_MIN_DEF,
    parameter logic [N_W-1:0]   RAMP_STEP = RAMP_STEP_DEF,
    parameter logic [DIV_W-1:0] RAMP_DIV  = RAMP_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           avto,
    input  logic           start,
    input  logic           stop,
    input  logic [N_W-1:0] man_n,
    input  logic           tr_en,
    input  logic [N_W-1:0] tr_n,
    output logic [N_W-1:0] n,
    output logic           drv_en_SM,
    output logic [1:0]     state,
    output logic           busy
);

    state_t         st_q, st_nxt;
    logic [N_W-1:0] n_nxt;
    logic           drv_nxt;
    logic           mode_q, man_q;
    logic           man_run_c, run_c;
    logic [N_W-1:0] tgt_c, ramp_c, stop_c;
    logic           tick, div_clr_c;

    // Stop beats start; the latch's next value feeds run so a start pulse acts at once.
    assign man_run_c = !stop && (start || man_q);
    assign run_c     = (mode_q ? tr_en : man_run_c) && (avto == mode_q);
    assign tgt_c     = clamp_n(mode_q ? tr_n : man_n, N_MIN, N_START);
    assign div_clr_c = (st_q == ST_IDLE);

    // Differences are only formed on the side where they cannot underflow.
    assign ramp_c = (n > tgt_c) ? ((n - tgt_c > RAMP_STEP) ? n - RAMP_STEP : tgt_c)
                                : ((tgt_c - n > RAMP_STEP) ? n + RAMP_STEP : tgt_c);
    assign stop_c = (N_START - n <= RAMP_STEP) ? N_START : n + RAMP_STEP;

    ramp_tick_div #(
        .RAMP_DIV(RAMP_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clear(div_clr_c),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= avto;
            man_q  <= 1'b0;
        end else begin
            if (st_q == ST_IDLE) mode_q <= avto;
            man_q <= !mode_q && man_run_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= ST_IDLE;
            n         <= N_START;
            drv_en_SM <= 1'b0;
            busy      <= 1'b0;
        end else begin
            st_q      <= st_nxt;
            n         <= n_nxt;
            drv_en_SM <= drv_nxt;
            busy      <= drv_nxt;
        end
    end

    always_comb begin
        st_nxt = st_q;
        case (st_q)
            ST_IDLE: begin
                if (run_c) st_nxt = ST_RAMP;
            end
            ST_RAMP: begin
                if (!run_c)            st_nxt = ST_STOPPING;
                else if (n == tgt_c)   st_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!run_c)            st_nxt = ST_STOPPING;
                else if (n != tgt_c)   st_nxt = ST_RAMP;
            end
            ST_STOPPING: begin
                if (run_c)                          st_nxt = ST_RAMP;
                else if (tick && stop_c == N_START) st_nxt = ST_IDLE;
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    // Period only moves on divider ticks; run requests suppress the stop step.
    always_comb begin
        n_nxt   = n;
        drv_nxt = (st_nxt != ST_IDLE);
        case (st_q)
            ST_RAMP:     if (run_c && tick)  n_nxt = ramp_c;
            ST_STOPPING: if (!run_c && tick) n_nxt = stop_c;
            default:     n_nxt = n;
        endcase
    end

    assign state = st_q;

endmodule

// File: tb/tb_step_ramp_ctrl.sv
// Scoreboard bench for step_ramp_ctrl: expected output-change events are queued
// by the stimulus and checked by a monitor whenever the outputs change.
module tb_step_ramp_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic        clk = 1'b0;
    logic        rst, avto, start, stop, tr_en;
    logic [16:0] man_n, tr_n, n;
    logic        drv_en_SM, busy;
    logic [1:0]  state;

    always #10 clk = ~clk;

    step_ramp_ctrl #(
        .N_START  (17'd100),
        .N_MIN    (17'd20),
        .RAMP_STEP(17'd10),
        .RAMP_DIV (16'd4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .avto     (avto),
        .start    (start),
        .stop     (stop),
        .man_n    (man_n),
        .tr_en    (tr_en),
        .tr_n     (tr_n),
        .n        (n),
        .drv_en_SM(drv_en_SM),
        .state    (state),
        .busy     (busy)
    );

    // gap = required negedge count since the previous event, 0 = don't care
    typedef struct {
        logic [1:0]  st;
        logic [16:0] n;
        logic        drv;
        logic        busy;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   evt = 0;
    bit   mon_en = 1'b0;
    bit   prev_valid = 1'b0;
    logic [20:0] prev;

    task automatic push(input logic [1:0] st, input int nv, input logic drv, input int gap);
        exp_t e;
        e.st   = st;
        e.n    = 17'(nv);
        e.drv  = drv;
        e.busy = drv;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        logic [20:0] cur;
        exp_t        e;
        cyc++;
        if (mon_en) begin
            cur = {state, n, drv_en_SM, busy};
            if (!prev_valid || cur != prev) begin
                checks++;
                evt++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_evt%0d got st=%0d n=%0d drv=%b busy=%b required no change",
                             evt, state, n, drv_en_SM, busy);
                end else begin
                    e = exp_q.pop_front();
                    if (state !== e.st || n !== e.n || drv_en_SM !== e.drv || busy !== e.busy ||
                        (e.gap != 0 && (cyc - last_cyc) != e.gap)) begin
                        failures++;
                        $display("FAIL evt%0d got st=%0d n=%0d drv=%b busy=%b gap=%0d required st=%0d n=%0d drv=%b busy=%b gap=%0d",
                                 evt, state, n, drv_en_SM, busy, cyc - last_cyc,
                                 e.st, e.n, e.drv, e.busy, e.gap);
                    end
                end
                last_cyc = cyc;
            end
            prev       = cur;
            prev_valid = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; avto = 1'b0; start = 1'b0; stop = 1'b0;
        tr_en = 1'b0; man_n = 17'd50; tr_n = 17'd45;
        repeat (3) @(negedge clk);
        push(S_IDLE, 100, 1'b0, 0);
        mon_en = 1'b1;
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // manual start to 50
        push(S_RAMP, 100, 1'b1, 0);
        push(S_RAMP, 90, 1'b1, 4);
        push(S_RAMP, 80, 1'b1, 4);
        push(S_RAMP, 70, 1'b1, 4);
        push(S_RAMP, 60, 1'b1, 4);
        push(S_RAMP, 50, 1'b1, 4);
        push(S_RUN,  50, 1'b1, 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_drain(100);
        repeat (20) @(negedge clk);

        // stop from RUN
        push(S_STOP, 50, 1'b1, 0);
        push(S_STOP, 60, 1'b1, 0);
        push(S_STOP, 70, 1'b1, 4);
        push(S_STOP, 80, 1'b1, 4);
        push(S_STOP, 90, 1'b1, 4);
        push(S_IDLE, 100, 1'b0, 4);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        wait_drain(100);
        repeat (20) @(negedge clk);

        // start and stop together: nothing happens
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        repeat (12) @(negedge clk);
        chk("ss_state", int'(state), 0);
        chk("ss_n", int'(n), 100);
        chk("ss_drv", int'(drv_en_SM), 0);

        // tracker, target clamped to N_MIN
        push(S_RAMP, 100, 1'b1, 0);
        for (int v = 90; v >= 20; v -= 10) push(S_RAMP, v, 1'b1, 4);
        push(S_RUN, 20, 1'b1, 1);
        @(negedge clk); avto = 1'b1; tr_en = 1'b1; tr_n = 17'd5;
        wait_drain(100);
        repeat (10) @(negedge clk);

        // tracker retarget to 45
        push(S_RAMP, 20, 1'b1, 0);
        push(S_RAMP, 30, 1'b1, 0);
        push(S_RAMP, 40, 1'b1, 4);
        push(S_RAMP, 45, 1'b1, 4);
        push(S_RUN,  45, 1'b1, 1);
        @(negedge clk); tr_n = 17'd45;
        wait_drain(100);
        repeat (10) @(negedge clk);

        // avto drops in RUN: controlled stop, no automatic restart
        push(S_STOP, 45, 1'b1, 0);
        push(S_STOP, 55, 1'b1, 0);
        push(S_STOP, 65, 1'b1, 4);
        push(S_STOP, 75, 1'b1, 4);
        push(S_STOP, 85, 1'b1, 4);
        push(S_STOP, 95, 1'b1, 4);
        push(S_IDLE, 100, 1'b0, 4);
        @(negedge clk); avto = 1'b0;
        wait_drain(100);
        repeat (20) @(negedge clk);

        // restart manually, reset mid-ramp at n=70
        push(S_RAMP, 100, 1'b1, 0);
        push(S_RAMP, 90, 1'b1, 4);
        push(S_RAMP, 80, 1'b1, 4);
        push(S_RAMP, 70, 1'b1, 4);
        push(S_IDLE, 100, 1'b0, 2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wait_drain(20);
        repeat (20) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_state", int'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_ramp_ctrl.md
STEP_RAMP_CTRL -- requirements
Module: step_ramp_ctrl

Interface
REQ-001 Parameter N_START, default 17'd8333, is the start/stop step period in clk cycles (6 kHz at 50 MHz).
REQ-002 Parameter N_MIN, default 17'd1000, is the minimum step period in clk cycles (50 kHz).
REQ-003 Parameter RAMP_STEP, default 17'd16, is the period change per ramp tick.
REQ-004 Parameter RAMP_DIV, default 16'd5000, is the number of clk cycles per ramp tick.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port clk, input, 1: 50 MHz system clock.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port avto, input, 1: source select (1 = tracker/auto, 0 = manual).
REQ-009 Port start, input, 1: manual run request pulse.
REQ-010 Port stop, input, 1: manual stop request pulse.
REQ-011 Port man_n, input, 17: manual target period.
REQ-012 Port tr_en, input, 1: tracker run request (level).
REQ-013 Port tr_n, input, 17: tracker target period.
REQ-014 Port n, output, 17: period driven to the pulse generator.
REQ-015 Port drv_en_SM, output, 1: stepper driver/pulse-generator enable.
REQ-016 Port state, output, 2: FSM state (0 IDLE, 1 RAMP, 2 RUN, 3 STOPPING).
REQ-017 Port busy, output, 1: high when state is not IDLE.

Function
REQ-018 Mode latch mode_q SHALL capture avto on every IDLE cycle and hold it outside IDLE.
REQ-019 Manual run latch: start sets it, stop clears it, and stop wins when both are high in the same cycle; it is cleared whenever mode_q=1.
REQ-020 run = (mode_q ? tr_en : manual latch) AND (avto == mode_q); an avto change outside IDLE forces run=0.
REQ-021 Target tgt = selected man_n/tr_n clamped to [N_MIN, N_START], using compares before any arithmetic.
REQ-022 IDLE: n=N_START, drv_en_SM=0; when run=1, go to RAMP on the next edge, set drv_en_SM=1 and clear the divider.
REQ-023 The divider SHALL count 0..RAMP_DIV-1 in non-IDLE states; a tick occurs at RAMP_DIV-1, and the divider then wraps to 0.
REQ-024 RAMP: on each tick, n moves toward tgt by at most RAMP_STEP in either direction, never overshooting and never leaving [N_MIN, N_START].
REQ-025 RAMP goes to RUN on the edge after n==tgt; RUN goes back to RAMP when tgt != n.
REQ-026 RAMP or RUN with run=0 SHALL go to STOPPING on the next edge; run has priority over target changes.
REQ-027 STOPPING: on each tick, n = min(n+RAMP_STEP, N_START); on the tick where n reaches N_START, go to IDLE with drv_en_SM=0 on the same edge.
REQ-028 In STOPPING, if run=1 with unchanged mode_q, go to RAMP on the next edge; the divider is not cleared.
REQ-029 n SHALL change only on ticks or on reset; drv_en_SM and busy are registered.

Reset
REQ-030 On rst: state=IDLE, n=N_START, drv_en_SM=0, busy=0, divider=0, manual latch=0, mode_q=avto.
REQ-031 rst asserted mid-operation SHALL abort immediately, with no deceleration ramp, and take priority over all other inputs.

Structure
REQ-032 The state encoding and the default N_START/N_MIN/RAMP_STEP/RAMP_DIV constants SHALL live in a shared package, step_ctrl_pkg.
REQ-033 The ramp divider SHALL be one sub-module, ramp_tick_div (clear input, tick output); the FSM and arithmetic stay in step_ramp_ctrl.

Verification
Bench parameters for all scenarios: N_START=100, N_MIN=20, RAMP_STEP=10, RAMP_DIV=4.
REQ-034 Manual start, man_n=50, avto=0: RAMP and drv_en_SM=1 one edge after start; n steps 90, 80, 70, 60, 50, one tick every 4 cycles; then RUN, n holds at 50.
REQ-035 Start and stop in the same cycle while IDLE: the block stays IDLE, drv_en_SM=0, n=100.
REQ-036 Stop pulse in RUN at n=50: STOPPING; n steps 60, 70, 80, 90, 100; then IDLE with drv_en_SM=0.
REQ-037 avto=1, tr_en=1, tr_n=5: tgt clamps to 20 and n ramps to 20 and holds; then tr_n=45: n goes 30, 40, 45, then RUN.
REQ-038 avto toggles 1->0 while in RUN: STOPPING, ramp to 100, then IDLE; a new manual start pulse is required to restart.
REQ-039 rst mid-RAMP at n=70: the next edge gives IDLE, n=100, drv_en_SM=0, busy=0, manual latch cleared.
